timer_prog_seq: RTL and testbench
=================================

// Module: timer_prog_seq
// PURPOSE
//  Upstream programmer for the PWM timer. Holds a small table of timer profiles (period, duty, repeat count).
//  On a go request it walks the profiles in order, doing four steps per profile:
//  writes the three timer registers, pulses the timer start, then waits for the timer's end pulse.
//  It then repeats the list once or forever, and replaces the testbench-driven we/addr/wdata/start stimulus.
// PARAMETERS
//  NPROF    4      number of profile slots in the table
//  IDXW     2      profile index width, must equal clog2(NPROF)
//  TIMEOUT  65535  max cycles in WAIT for i_tmr_end; 0 disables the timeout
// PORTS
//  i_clk        in   1      clock, rising edge
//  i_rst_n      in   1      asynchronous reset, active-low
//  i_cfg_we     in   1      table write strobe
//  i_cfg_idx    in   IDXW   profile slot to write
//  i_cfg_field  in   2      0=period, 1=duty, 2=count; 3=ignored
//  i_cfg_wdata  in   16     table write data
//  i_num_prof   in   IDXW+1 profiles per pass; sampled at go; values >NPROF saturate to NPROF
//  i_loop       in   1      sampled at go; 1=restart at slot 0 after last profile
//  i_go         in   1      start sequence (level is sampled in IDLE only)
//  i_abort      in   1      stop sequence, return to IDLE
//  i_tmr_end    in   1      timer end pulse (timer o_timer_end)
//  o_tmr_we     out  1      timer register write enable
//  o_tmr_addr   out  2      timer register address: 0=period, 1=duty, 2=count
//  o_tmr_wdata  out  16     timer register write data
//  o_tmr_start  out  1      one-cycle timer start pulse
//  o_busy       out  1      high whenever the FSM is not in IDLE
//  o_prof_idx   out  IDXW   slot currently being programmed or run
//  o_done       out  1      one-cycle pulse when a non-looping sequence completes
//  o_err        out  1      sticky timeout flag; cleared by the next accepted go
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, table contents 0, index 0.
//  - All outputs are registered; the timer samples we/addr/wdata on the rising edge.
//  - FSM states and transitions (one state per clock except WAIT):
//      IDLE   -> WR_PER   on go, if the saturated num_prof is >0
//      WR_PER -> WR_DUTY -> WR_CNT -> START -> WAIT
//      WAIT   -> NEXT     on i_tmr_end
//      NEXT   -> WR_PER (more profiles, or loop) / IDLE (done)
//  - Output timing:
//      go sampled at edge N: WR_PER outputs (we=1, addr=0, wdata=period[idx]) are visible in cycle N+1.
//      Duty and count writes follow on consecutive cycles.
//      o_tmr_start=1 for exactly the cycle after the count write; we=0 during that cycle.
//  - Index advance:
//      NEXT increments the index. At index num_prof-1 it wraps to 0 if loop=1, else it goes to IDLE.
//      o_done pulses in the first IDLE cycle after a non-looping sequence completes.
//  - num_prof=0 at go: no timer writes; o_done pulses in the next cycle; busy stays 0.
//  - go while busy: ignored. num_prof and loop are only captured at go.
//  - abort: in any state, FSM returns to IDLE at the next edge.
//      we and start drop; no o_done; o_err is unchanged.
//      abort wins over a simultaneous i_tmr_end or go.
//  - i_tmr_end outside WAIT: ignored, not remembered.
//  - Timeout: the WAIT counter starts at 0 on WAIT entry.
//      If it reaches TIMEOUT without an end pulse: o_err<=1, FSM->IDLE, no o_done.
//  - Table writes: allowed at any time, including while busy.
//      A write to the slot being read in the same cycle: the old value is driven; the new value applies on the next visit.
//      Field 3 writes are dropped.
//  - Count=0 or duty>period: forwarded unchanged; interpreting them is the timer's responsibility.
// TESTING
//  1 Single profile:
//      Load slot0 = {20,10,2}, num_prof=1, loop=0, pulse go.
//      -> writes (0,20), (1,10), (2,2) on 3 consecutive cycles, start on the 4th.
//      -> i_tmr_end 40 cycles later gives o_done one cycle after NEXT; busy then falls.
//  2 Three profiles, no loop:
//      Slots {20,10,2}, {8,4,1}, {30,15,3}, num_prof=3.
//      -> o_prof_idx steps 0,1,2, with 3 write groups and 3 starts.
//      -> exactly one o_done, after the third end pulse.
//  3 Loop and abort:
//      num_prof=2, loop=1, end returned every 50 cycles.
//      -> index sequence 0,1,0,1,... with no o_done.
//      -> abort issued in WR_DUTY gives IDLE next cycle, we=0, no start.
//  4 Timeout:
//      TIMEOUT=16, never assert end.
//      -> o_err=1 and busy=0 exactly 16 cycles after WAIT entry.
//      -> the next go clears o_err.
//  5 Corner cases:
//      num_prof=0 -> o_done with no writes.
//      num_prof=7 with NPROF=4 -> 4 profiles run.
//      go while busy -> ignored.
//      Spurious end during WR_PER -> ignored.
//  6 Reset:
//      Assert i_rst_n=0 mid-WAIT -> all outputs 0 immediately; the table reads back 0 at the next go.

Source files
------------

// File: rtl/timer_prog_seq.sv
// rtl/timer_prog_seq.sv - profile-table sequencer that programs and starts the PWM timer
module timer_prog_seq #(
    parameter int          NPROF   = 4,
    parameter int          IDXW    = 2,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_cfg_we,
    input  logic [IDXW-1:0] i_cfg_idx,
    input  logic [1:0]      i_cfg_field,
    input  logic [15:0]     i_cfg_wdata,
    input  logic [IDXW:0]   i_num_prof,
    input  logic            i_loop,
    input  logic            i_go,
    input  logic            i_abort,
    input  logic            i_tmr_end,
    output logic            o_tmr_we,
    output logic [1:0]      o_tmr_addr,
    output logic [15:0]     o_tmr_wdata,
    output logic            o_tmr_start,
    output logic            o_busy,
    output logic [IDXW-1:0] o_prof_idx,
    output logic            o_done,
    output logic            o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_PER, S_WR_DUTY, S_WR_CNT, S_START, S_WAIT, S_NEXT
    } state_t;

    localparam logic [IDXW:0] NPROF_W = (IDXW+1)'(NPROF);
    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

    // Profile table
    logic [15:0] per_q  [NPROF];
    logic [15:0] duty_q [NPROF];
    logic [15:0] cnt_q  [NPROF];

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW:0]   nprof_q, nprof_d;
    logic            loop_q, loop_d;
    logic [15:0]     tcnt_q, tcnt_d;
    logic            done_d, err_d;

    logic            tmr_we_d, tmr_start_d, busy_d;
    logic [1:0]      tmr_addr_d;
    logic [15:0]     tmr_wdata_d;

    logic [IDXW:0]   nprof_sat;
    logic            last_prof;

    assign nprof_sat = (i_num_prof > NPROF_W) ? NPROF_W : i_num_prof;
    assign last_prof = ({1'b0, idx_q} == (nprof_q - 1'b1));

    // Table write port; field 3 is dropped, reads elsewhere see the pre-edge value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NPROF; i++) begin
                per_q[i]  <= '0;
                duty_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (i_cfg_we) begin
            case (i_cfg_field)
                2'd0:    per_q[i_cfg_idx]  <= i_cfg_wdata;
                2'd1:    duty_q[i_cfg_idx] <= i_cfg_wdata;
                2'd2:    cnt_q[i_cfg_idx]  <= i_cfg_wdata;
                default: ;
            endcase
        end
    end

    // State, sequencing context and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            nprof_q     <= '0;
            loop_q      <= 1'b0;
            tcnt_q      <= '0;
            o_tmr_we    <= 1'b0;
            o_tmr_addr  <= '0;
            o_tmr_wdata <= '0;
            o_tmr_start <= 1'b0;
            o_busy      <= 1'b0;
            o_prof_idx  <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nprof_q     <= nprof_d;
            loop_q      <= loop_d;
            tcnt_q      <= tcnt_d;
            o_tmr_we    <= tmr_we_d;
            o_tmr_addr  <= tmr_addr_d;
            o_tmr_wdata <= tmr_wdata_d;
            o_tmr_start <= tmr_start_d;
            o_busy      <= busy_d;
            o_prof_idx  <= idx_d;
            o_done      <= done_d;
            o_err       <= err_d;
        end
    end

    // Next-state logic; abort overrides every other event
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nprof_d = nprof_q;
        loop_d  = loop_q;
        tcnt_d  = tcnt_q;
        done_d  = 1'b0;
        err_d   = o_err;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_go) begin
                        err_d   = 1'b0;
                        nprof_d = nprof_sat;
                        loop_d  = i_loop;
                        idx_d   = '0;
                        if (nprof_sat != '0) state_d = S_WR_PER;
                        else                 done_d  = 1'b1;
                    end
                end
                S_WR_PER:  state_d = S_WR_DUTY;
                S_WR_DUTY: state_d = S_WR_CNT;
                S_WR_CNT:  state_d = S_START;
                S_START: begin
                    state_d = S_WAIT;
                    tcnt_d  = '0;
                end
                S_WAIT: begin
                    if (i_tmr_end) begin
                        state_d = S_NEXT;
                    end else if ((TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
                S_NEXT: begin
                    if (!last_prof) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_WR_PER;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = S_WR_PER;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so every output is registered
    always_comb begin
        tmr_we_d    = 1'b0;
        tmr_addr_d  = 2'd0;
        tmr_wdata_d = '0;
        tmr_start_d = 1'b0;
        busy_d      = (state_d != S_IDLE);
        case (state_d)
            S_WR_PER: begin
                tmr_we_d    = 1'b1;
                tmr_addr_d  = 2'd0;
                tmr_wdata_d = per_q[idx_d];
            end
            S_WR_DUTY: begin
                tmr_we_d    = 1'b1;
                tmr_addr_d  = 2'd1;
                tmr_wdata_d = duty_q[idx_d];
            end
            S_WR_CNT: begin
                tmr_we_d    = 1'b1;
                tmr_addr_d  = 2'd2;
                tmr_wdata_d = cnt_q[idx_d];
            end
            S_START: tmr_start_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_timer_prog_seq.sv
// tb/tb_timer_prog_seq.sv - directed self-checking bench for timer_prog_seq
module tb_timer_prog_seq;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n, cfg_we, loop_i, go, abort_i, tmr_end;
    logic [1:0]  cfg_idx, cfg_field;
    logic [15:0] cfg_wdata;
    logic [2:0]  num_prof;
    logic        tmr_we, tmr_start, busy, done, err;
    logic [1:0]  tmr_addr, prof_idx;
    logic [15:0] tmr_wdata;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    timer_prog_seq #(.NPROF(4), .IDXW(2), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_field(cfg_field), .i_cfg_wdata(cfg_wdata),
        .i_num_prof(num_prof), .i_loop(loop_i), .i_go(go), .i_abort(abort_i), .i_tmr_end(tmr_end),
        .o_tmr_we(tmr_we), .o_tmr_addr(tmr_addr), .o_tmr_wdata(tmr_wdata), .o_tmr_start(tmr_start),
        .o_busy(busy), .o_prof_idx(prof_idx), .o_done(done), .o_err(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int idx, input int field, input int data);
        cfg_we    = 1'b1;
        cfg_idx   = idx[1:0];
        cfg_field = field[1:0];
        cfg_wdata = data[15:0];
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic load(input int idx, input int p, input int d, input int c);
        cfg(idx, 0, p);
        cfg(idx, 1, d);
        cfg(idx, 2, c);
    endtask

    task automatic go_req(input int n, input bit lp);
        num_prof = n[2:0];
        loop_i   = lp;
        go       = 1'b1;
        step();
        go       = 1'b0;
    endtask

    // Called in the WR_PER cycle; returns in the first WAIT cycle
    task automatic group(input int idx, input int p, input int d, input int c);
        chk("per_we",    tmr_we,    1);
        chk("per_addr",  tmr_addr,  0);
        chk("per_data",  tmr_wdata, p);
        chk("per_idx",   prof_idx,  idx);
        chk("per_busy",  busy,      1);
        chk("per_done",  done,      0);
        step();
        chk("duty_we",   tmr_we,    1);
        chk("duty_addr", tmr_addr,  1);
        chk("duty_data", tmr_wdata, d);
        step();
        chk("cnt_we",    tmr_we,    1);
        chk("cnt_addr",  tmr_addr,  2);
        chk("cnt_data",  tmr_wdata, c);
        step();
        chk("start",     tmr_start, 1);
        chk("start_we",  tmr_we,    0);
        step();
        chk("wait_start", tmr_start, 0);
        chk("wait_busy",  busy,      1);
    endtask

    // Returns in the NEXT cycle
    task automatic end_after(input int n);
        repeat (n) step();
        tmr_end = 1'b1;
        step();
        tmr_end = 1'b0;
        chk("next_busy", busy, 1);
        chk("next_done", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
        num_prof = '0; loop_i = 1'b0; go = 1'b0; abort_i = 1'b0; tmr_end = 1'b0;
        step();
        step();
        chk("rst_busy",  busy,      0);
        chk("rst_we",    tmr_we,    0);
        chk("rst_start", tmr_start, 0);
        chk("rst_done",  done,      0);
        chk("rst_err",   err,       0);
        chk("rst_idx",   prof_idx,  0);
        chk("rst_wdata", tmr_wdata, 0);
        rst_n = 1'b1;
        step();

        // 1: single profile
        load(0, 20, 10, 2);
        cfg(0, 3, 99);
        go_req(1, 1'b0);
        group(0, 20, 10, 2);
        end_after(38);
        step();
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        step();
        chk("t1_done_pulse", done, 0);

        // 2: three profiles, no loop
        load(1, 8, 4, 1);
        load(2, 30, 15, 3);
        go_req(3, 1'b0);
        group(0, 20, 10, 2);
        end_after(5);
        step();
        group(1, 8, 4, 1);
        end_after(5);
        step();
        group(2, 30, 15, 3);
        end_after(5);
        step();
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        step();
        chk("t2_done_once", done, 0);

        // 3: loop, then abort in WR_DUTY
        go_req(2, 1'b1);
        group(0, 20, 10, 2);
        end_after(45);
        step();
        group(1, 8, 4, 1);
        end_after(45);
        step();
        group(0, 20, 10, 2);
        end_after(45);
        step();
        chk("t3_wrap_we",  tmr_we,   1);
        chk("t3_wrap_idx", prof_idx, 1);
        chk("t3_no_done",  done,     0);
        step();
        chk("t3_duty_addr", tmr_addr, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t3_ab_busy",  busy,      0);
        chk("t3_ab_we",    tmr_we,    0);
        chk("t3_ab_start", tmr_start, 0);
        chk("t3_ab_done",  done,      0);
        step();
        chk("t3_ab_start2", tmr_start, 0);
        chk("t3_ab_done2",  done,      0);

        // 4: timeout, then go with num_prof=0 clears err and pulses done
        go_req(1, 1'b0);
        group(0, 20, 10, 2);
        repeat (TO - 1) step();
        chk("t4_pre_busy", busy, 1);
        chk("t4_pre_err",  err,  0);
        step();
        chk("t4_err",  err,  1);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        step();
        chk("t4_err_sticky", err, 1);
        go_req(0, 1'b0);
        chk("t4_err_clr", err,    0);
        chk("t5_np0_done", done,  1);
        chk("t5_np0_busy", busy,  0);
        chk("t5_np0_we",   tmr_we, 0);
        step();
        chk("t5_np0_done2", done, 0);

        // 5: saturation, go while busy, spurious end, writes while busy
        cfg(3, 0, 5);
        cfg(3, 1, 3);
        cfg(3, 2, 7);
        go_req(7, 1'b0);
        chk("t5_per_data", tmr_wdata, 20);
        tmr_end = 1'b1;
        go = 1'b1;
        step();
        tmr_end = 1'b0;
        go = 1'b0;
        chk("t5_duty_addr", tmr_addr,  1);
        chk("t5_duty_data", tmr_wdata, 10);
        step();
        chk("t5_cnt_addr", tmr_addr, 2);
        step();
        chk("t5_start", tmr_start, 1);
        step();
        cfg(1, 0, 77);
        step();
        step();
        chk("t5_spur_we",   tmr_we, 0);
        chk("t5_spur_busy", busy,   1);
        end_after(5);
        step();
        group(1, 77, 4, 1);
        end_after(5);
        cfg(2, 0, 31);
        group(2, 30, 15, 3);
        end_after(5);
        step();
        group(3, 5, 3, 7);
        end_after(5);
        step();
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);

        // 6: async reset mid-WAIT clears outputs and table
        go_req(1, 1'b0);
        group(0, 20, 10, 2);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_busy",  busy,      0);
        chk("t6_we",    tmr_we,    0);
        chk("t6_start", tmr_start, 0);
        chk("t6_idx",   prof_idx,  0);
        chk("t6_done",  done,      0);
        chk("t6_err",   err,       0);
        step();
        rst_n = 1'b1;
        step();
        go_req(1, 1'b0);
        chk("t6_per_we",   tmr_we,    1);
        chk("t6_per_data", tmr_wdata, 0);
        step();
        chk("t6_duty_data", tmr_wdata, 0);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t6_ab_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
